// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath blocks.
//   DATA_W : default width of activations and gradients
//   act_t  : signed two's-complement activation/gradient sample
package cnn_pkg;

  localparam int DATA_W = 13;

  typedef logic signed [DATA_W-1:0] act_t;

endpackage

// File: rtl/relu_mask_fifo.sv
// relu_mask_fifo: 1-bit wide, DEPTH-entry synchronous FIFO holding ReLU mask bits.
// The head entry is presented combinationally on rd_bit so the consumer can use it
// in the same cycle it pops.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   synchronous reset, active low
//   flush    in   synchronous clear (priority over push/pop)
//   push     in   write push_bit at the tail (ignored when full)
//   push_bit in   mask bit to store
//   pop      in   discard the head entry (ignored when empty)
//   rd_bit   out  mask bit at the head
//   full     out  count == DEPTH
//   empty    out  count == 0
//   count    out  entries currently stored
module relu_mask_fifo #(
  parameter int DEPTH = 256,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             push_bit,
  input  logic             pop,
  output logic             rd_bit,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic             mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             push_ok, pop_ok;

  // The count alone decides full/empty; pointers simply wrap modulo DEPTH.
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  assign rd_bit = mem_reg[rd_ptr_reg];

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (pop_ok)  rd_ptr_next = rd_ptr_reg + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= push_bit;
  end

endmodule

// File: rtl/relu_grad_gate.sv
// relu_grad_gate: backward-pass partner of the forward ReLU.
// Forward pass records mask = (pre-activation >= 0) per sample in a FIFO; backward pass
// gates each incoming gradient with the oldest stored mask and drives the result
// through a registered valid/ready output stage.
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   synchronous reset, active low
//   flush         in   synchronous clear of mask buffer and output register
//   fwd_valid     in   pre-activation sample valid
//   fwd_ready     out  mask buffer has room
//   fwd_a         in   signed pre-activation
//   bwd_in_valid  in   upstream gradient valid
//   bwd_in_ready  out  gradient accepted when valid & ready
//   bwd_in_grad   in   signed upstream gradient
//   bwd_out_valid out  gated gradient valid
//   bwd_out_ready in   downstream accepts gated gradient
//   bwd_out_grad  out  signed gated gradient (mask ? grad : 0)
//   mask_count    out  mask bits currently stored
module relu_grad_gate #(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int DEPTH  = 256,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     fwd_valid,
  output logic                     fwd_ready,
  input  logic signed [DATA_W-1:0] fwd_a,
  input  logic                     bwd_in_valid,
  output logic                     bwd_in_ready,
  input  logic signed [DATA_W-1:0] bwd_in_grad,
  output logic                     bwd_out_valid,
  input  logic                     bwd_out_ready,
  output logic signed [DATA_W-1:0] bwd_out_grad,
  output logic [CNT_W-1:0]         mask_count
);

  logic                     fifo_full, fifo_empty, head_mask;
  logic                     push, pop;
  logic                     out_valid_reg, out_valid_next;
  logic signed [DATA_W-1:0] out_grad_reg, out_grad_next;

  // Readiness depends only on registered state, never on the incoming valids,
  // so a freed slot shows up one cycle after the pop that freed it.
  assign fwd_ready    = ~fifo_full;
  assign bwd_in_ready = ~fifo_empty & (~out_valid_reg | bwd_out_ready);

  assign push = fwd_valid & fwd_ready;
  assign pop  = bwd_in_valid & bwd_in_ready;

  // Sign bit clear means a >= 0, which is exactly when the forward ReLU passes a.
  relu_mask_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_mask_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push     (push),
    .push_bit (~fwd_a[DATA_W-1]),
    .pop      (pop),
    .rd_bit   (head_mask),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (mask_count)
  );

  // Output stage: load on pop, drop valid on a drain without a new pop, else hold.
  // The data value is kept after a drain so the bus does not toggle needlessly.
  always_comb begin
    out_valid_next = out_valid_reg;
    out_grad_next  = out_grad_reg;
    if (pop) begin
      out_valid_next = 1'b1;
      out_grad_next  = head_mask ? bwd_in_grad : '0;
    end else if (bwd_out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      out_valid_reg <= 1'b0;
      out_grad_reg  <= '0;
    end else begin
      out_valid_reg <= out_valid_next;
      out_grad_reg  <= out_grad_next;
    end
  end

  assign bwd_out_valid = out_valid_reg;
  assign bwd_out_grad  = out_grad_reg;

endmodule

// File: tb/tb_relu_grad_gate.sv
module tb_relu_grad_gate;
  import cnn_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             fwd_valid;
  logic             fwd_ready;
  act_t             fwd_a;
  logic             bwd_in_valid;
  logic             bwd_in_ready;
  act_t             bwd_in_grad;
  logic             bwd_out_valid;
  logic             bwd_out_ready;
  act_t             bwd_out_grad;
  logic [CNT_W-1:0] mask_count;

  int checks = 0;
  int passes = 0;

  // Reference model: a queue of mask decisions plus the output slot.
  bit   m_q[$];
  bit   m_ov;
  act_t m_og;

  always #5 clk = ~clk;

  relu_grad_gate #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .fwd_valid     (fwd_valid),
    .fwd_ready     (fwd_ready),
    .fwd_a         (fwd_a),
    .bwd_in_valid  (bwd_in_valid),
    .bwd_in_ready  (bwd_in_ready),
    .bwd_in_grad   (bwd_in_grad),
    .bwd_out_valid (bwd_out_valid),
    .bwd_out_ready (bwd_out_ready),
    .bwd_out_grad  (bwd_out_grad),
    .mask_count    (mask_count)
  );

  function automatic bit model_fwd_ready();
    return m_q.size() != DEPTH;
  endfunction

  function automatic bit model_bwd_ready();
    return (m_q.size() != 0) && (!m_ov || bwd_out_ready);
  endfunction

  // Advance model and DUT by one clock using the currently driven inputs.
  task automatic tick();
    bit push_ok;
    bit pop_ok;
    bit m;
    push_ok = fwd_valid && model_fwd_ready();
    pop_ok  = bwd_in_valid && model_bwd_ready();
    if (!rst_n || flush) begin
      m_q.delete();
      m_ov = 1'b0;
      m_og = '0;
    end else begin
      if (pop_ok) begin
        m    = m_q.pop_front();
        m_og = m ? bwd_in_grad : act_t'(0);
        m_ov = 1'b1;
      end else if (bwd_out_ready) begin
        m_ov = 1'b0;
      end
      if (push_ok) m_q.push_back(fwd_a >= 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fwd_valid     = 1'b0;
    fwd_a         = '0;
    bwd_in_valid  = 1'b0;
    bwd_in_grad   = '0;
    bwd_out_ready = 1'b1;
  endtask

  task automatic do_flush();
    idle_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic push_one(input act_t a);
    fwd_valid = 1'b1;
    fwd_a     = a;
    tick();
    fwd_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    flush = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++; if (mask_count !== '0) $display("FAIL reset_count: got %0d expected 0", mask_count); else passes++;
    checks++; if (bwd_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bwd_out_valid); else passes++;
    checks++; if (bwd_out_grad !== act_t'(0)) $display("FAIL reset_out_grad: got %0d expected 0", bwd_out_grad); else passes++;
    checks++; if (fwd_ready !== 1'b1) $display("FAIL reset_fwd_ready: got %b expected 1", fwd_ready); else passes++;
    checks++; if (bwd_in_ready !== 1'b0) $display("FAIL reset_bwd_in_ready: got %b expected 0", bwd_in_ready); else passes++;
    $display("reset: count=%0d out_valid=%b fwd_ready=%b", mask_count, bwd_out_valid, fwd_ready);
  endtask

  task automatic test_masking();
    act_t a_v[4] = '{act_t'(5), act_t'(-3), act_t'(0), act_t'(-4096)};
    act_t g_v[4] = '{act_t'(100), act_t'(100), act_t'(-7), act_t'(4095)};
    act_t e_v[4] = '{act_t'(100), act_t'(0), act_t'(-7), act_t'(0)};
    do_flush();
    for (int i = 0; i < 4; i++) push_one(a_v[i]);
    checks++; if (mask_count !== CNT_W'(4)) $display("FAIL mask_count4: got %0d expected 4", mask_count); else passes++;
    bwd_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bwd_in_valid = 1'b1;
      bwd_in_grad  = g_v[i];
      checks++; if (bwd_in_ready !== 1'b1) $display("FAIL mask_in_ready[%0d]: got %b expected 1", i, bwd_in_ready); else passes++;
      tick();
      checks++; if (bwd_out_valid !== 1'b1) $display("FAIL mask_out_valid[%0d]: got %b expected 1", i, bwd_out_valid); else passes++;
      checks++; if (bwd_out_grad !== e_v[i]) $display("FAIL mask_out_grad[%0d]: got %0d expected %0d", i, bwd_out_grad, e_v[i]); else passes++;
      $display("mask: a=%0d grad=%0d out=%0d", a_v[i], g_v[i], bwd_out_grad);
    end
    bwd_in_valid = 1'b0;
    tick();
    checks++; if (bwd_out_valid !== 1'b0) $display("FAIL mask_drain_valid: got %b expected 0", bwd_out_valid); else passes++;
  endtask

  task automatic test_full();
    act_t a_v[5] = '{act_t'(1), act_t'(-1), act_t'(2), act_t'(-2), act_t'(3)};
    do_flush();
    fwd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fwd_a = a_v[i];
      tick();
    end
    fwd_a = a_v[4];
    checks++; if (mask_count !== CNT_W'(4)) $display("FAIL full_count: got %0d expected 4", mask_count); else passes++;
    checks++; if (fwd_ready !== 1'b0) $display("FAIL full_fwd_ready: got %b expected 0", fwd_ready); else passes++;
    tick();
    checks++; if (mask_count !== CNT_W'(4)) $display("FAIL full_stall_count: got %0d expected 4", mask_count); else passes++;
    bwd_in_valid = 1'b1;
    bwd_in_grad  = act_t'(50);
    tick();
    bwd_in_valid = 1'b0;
    checks++; if (fwd_ready !== 1'b1) $display("FAIL full_ready_after_pop: got %b expected 1", fwd_ready); else passes++;
    checks++; if (mask_count !== CNT_W'(3)) $display("FAIL full_count_after_pop: got %0d expected 3", mask_count); else passes++;
    tick();
    fwd_valid = 1'b0;
    checks++; if (mask_count !== CNT_W'(4)) $display("FAIL full_fifth_accepted: got %0d expected 4", mask_count); else passes++;
    for (int i = 0; i < 4; i++) begin
      bwd_in_valid = 1'b1;
      bwd_in_grad  = act_t'($urandom);
      tick();
      checks++; if (bwd_out_grad !== m_og) $display("FAIL full_drain_grad[%0d]: got %0d expected %0d", i, bwd_out_grad, m_og); else passes++;
      $display("full drain: out=%0d", bwd_out_grad);
    end
    bwd_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    act_t g0, g1, g2;
    g0 = act_t'($urandom);
    g1 = act_t'($urandom);
    g2 = act_t'($urandom);
    do_flush();
    for (int i = 0; i < 3; i++) push_one(act_t'($urandom_range(1, 4095)));
    bwd_out_ready = 1'b0;
    bwd_in_valid  = 1'b1;
    bwd_in_grad   = g0;
    checks++; if (bwd_in_ready !== 1'b1) $display("FAIL bp_first_ready: got %b expected 1", bwd_in_ready); else passes++;
    tick();
    bwd_in_grad = g1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bwd_in_ready !== 1'b0) $display("FAIL bp_blocked[%0d]: got %b expected 0", i, bwd_in_ready); else passes++;
      checks++; if (bwd_out_grad !== g0 || bwd_out_valid !== 1'b1) $display("FAIL bp_hold[%0d]: got %0d/%b expected %0d/1", i, bwd_out_grad, bwd_out_valid, g0); else passes++;
      checks++; if (mask_count !== CNT_W'(2)) $display("FAIL bp_count[%0d]: got %0d expected 2", i, mask_count); else passes++;
      tick();
    end
    bwd_out_ready = 1'b1;
    #1;
    checks++; if (bwd_in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", bwd_in_ready); else passes++;
    tick();
    checks++; if (bwd_out_grad !== g1 || bwd_out_valid !== 1'b1) $display("FAIL bp_out1: got %0d/%b expected %0d/1", bwd_out_grad, bwd_out_valid, g1); else passes++;
    bwd_in_grad = g2;
    tick();
    checks++; if (bwd_out_grad !== g2 || bwd_out_valid !== 1'b1) $display("FAIL bp_out2: got %0d/%b expected %0d/1", bwd_out_grad, bwd_out_valid, g2); else passes++;
    checks++; if (mask_count !== '0) $display("FAIL bp_empty: got %0d expected 0", mask_count); else passes++;
    bwd_in_valid = 1'b0;
    tick();
    $display("backpressure: g0=%0d g1=%0d g2=%0d", g0, g1, g2);
  endtask

  task automatic test_simultaneous();
    act_t ga, gb, gc;
    ga = act_t'($urandom);
    gb = act_t'($urandom);
    gc = act_t'($urandom);
    do_flush();
    push_one(act_t'(7));
    push_one(act_t'(-9));
    fwd_valid    = 1'b1;
    fwd_a        = act_t'(11);
    bwd_in_valid = 1'b1;
    bwd_in_grad  = ga;
    tick();
    fwd_valid = 1'b0;
    checks++; if (mask_count !== CNT_W'(2)) $display("FAIL simul_count: got %0d expected 2", mask_count); else passes++;
    checks++; if (bwd_out_grad !== ga) $display("FAIL simul_out0: got %0d expected %0d", bwd_out_grad, ga); else passes++;
    bwd_in_grad = gb;
    tick();
    checks++; if (bwd_out_grad !== act_t'(0)) $display("FAIL simul_out1: got %0d expected 0", bwd_out_grad); else passes++;
    bwd_in_grad = gc;
    tick();
    checks++; if (bwd_out_grad !== gc) $display("FAIL simul_out2: got %0d expected %0d", bwd_out_grad, gc); else passes++;
    bwd_in_valid = 1'b0;
    tick();
    $display("simultaneous: outs %0d,0,%0d", ga, gc);
  endtask

  task automatic test_flush();
    do_flush();
    for (int i = 0; i < 4; i++) push_one(act_t'($urandom_range(0, 4095)));
    bwd_out_ready = 1'b0;
    bwd_in_valid  = 1'b1;
    bwd_in_grad   = act_t'(123);
    tick();
    bwd_in_valid = 1'b0;
    checks++; if (mask_count !== CNT_W'(3) || bwd_out_valid !== 1'b1) $display("FAIL flush_pre: got %0d/%b expected 3/1", mask_count, bwd_out_valid); else passes++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (mask_count !== '0) $display("FAIL flush_count: got %0d expected 0", mask_count); else passes++;
    checks++; if (bwd_out_valid !== 1'b0) $display("FAIL flush_valid: got %b expected 0", bwd_out_valid); else passes++;
    checks++; if (bwd_out_grad !== act_t'(0)) $display("FAIL flush_grad: got %0d expected 0", bwd_out_grad); else passes++;
    bwd_in_valid = 1'b1;
    checks++; if (bwd_in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b expected 0", bwd_in_ready); else passes++;
    tick();
    bwd_in_valid = 1'b0;
    checks++; if (bwd_out_valid !== 1'b0) $display("FAIL flush_no_accept: got %b expected 0", bwd_out_valid); else passes++;
    $display("flush: count=%0d out_valid=%b", mask_count, bwd_out_valid);
  endtask

  task automatic test_random();
    int errs_before;
    errs_before = checks - passes;
    for (int i = 0; i < 400; i++) begin
      fwd_valid     = ($urandom_range(0, 2) != 0);
      fwd_a         = act_t'($urandom);
      bwd_in_valid  = ($urandom_range(0, 2) != 0);
      bwd_in_grad   = act_t'($urandom);
      bwd_out_ready = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 63) == 0);
      #1;
      checks++; if (fwd_ready !== model_fwd_ready()) $display("FAIL rnd_fwd_ready[%0d]: got %b expected %b", i, fwd_ready, model_fwd_ready()); else passes++;
      checks++; if (bwd_in_ready !== model_bwd_ready()) $display("FAIL rnd_bwd_ready[%0d]: got %b expected %b", i, bwd_in_ready, model_bwd_ready()); else passes++;
      tick();
      checks++; if (mask_count !== CNT_W'(m_q.size())) $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, mask_count, m_q.size()); else passes++;
      checks++; if (bwd_out_valid !== m_ov || bwd_out_grad !== m_og) $display("FAIL rnd_out[%0d]: got %b/%0d expected %b/%0d", i, bwd_out_valid, bwd_out_grad, m_ov, m_og); else passes++;
    end
    flush = 1'b0;
    $display("random: 400 cycles, %0d new errors", (checks - passes) - errs_before);
  endtask

  initial begin
    m_ov = 1'b0;
    m_og = '0;
    rst_n = 1'b1;
    flush = 1'b0;
    idle_inputs();
    test_reset();
    test_masking();
    test_full();
    test_backpressure();
    test_simultaneous();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
